// File: rtl/debug_pkg.sv
// Shared types and constants for the debug controller.
// Optional PC breakpoints are enabled with macro DEBUG_PC_BP_EN.
package debug_pkg;

   typedef enum logic [1:0] {
      StRunning = 2'd0,
      StHalted  = 2'd1,
      StStep    = 2'd2
   } dbg_state_e;

   typedef enum logic [2:0] {
      CauseNone    = 3'd0,
      CauseHost    = 3'd1,
      CauseEbreak  = 3'd2,
      CauseCycleBp = 3'd3,
      CausePcBp    = 3'd4,
      CauseStep    = 3'd5
   } halt_cause_e;

   localparam logic [14:0] AddrCtrl   = 15'h000;
   localparam logic [14:0] AddrStatus = 15'h001;
   localparam logic [14:0] AddrCycle  = 15'h002;
   localparam logic [14:0] AddrBpVal  = 15'h010;
   localparam logic [14:0] AddrBpCtrl = 15'h020;

   localparam int unsigned CtrlHalt   = 0;
   localparam int unsigned CtrlResume = 1;
   localparam int unsigned CtrlStep   = 2;
   localparam int unsigned CtrlClear  = 3;

   localparam int unsigned BpCtrlEn   = 0;
   localparam int unsigned BpCtrlType = 1;

   // Fixed priority among simultaneous halt sources.
   function automatic halt_cause_e sel_cause(input logic host, input logic ebreak,
                                             input logic cyc_bp, input logic pc_bp);
      if (host) begin
         return CauseHost;
      end else if (ebreak) begin
         return CauseEbreak;
      end else if (cyc_bp) begin
         return CauseCycleBp;
      end else if (pc_bp) begin
         return CausePcBp;
      end
      return CauseNone;
   endfunction

endpackage

// File: rtl/debug_bp_cmp.sv
// One breakpoint channel: value/control registers and match comparator.
// PC-type matching exists only when DEBUG_PC_BP_EN is defined.
module debug_bp_cmp
   import debug_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         val_we_i,
   input  logic         ctrl_we_i,
   input  logic [N-1:0] wdata_i,
   input  logic [N-1:0] cycle_count_i,
   input  logic [N-1:0] pc_i,
   input  logic         pc_suppress_i,
   output logic [N-1:0] val_o,
   output logic [1:0]   ctrl_o,
   output logic         cycle_match_o,
   output logic         pc_match_o
);

   logic [N-1:0] val_q;
   logic         en_q;
   logic         bp_type;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         val_q <= '0;
         en_q  <= 1'b0;
      end else begin
         if (val_we_i) begin
            val_q <= wdata_i;
         end
         if (ctrl_we_i) begin
            en_q <= wdata_i[BpCtrlEn];
         end
      end
   end

`ifdef DEBUG_PC_BP_EN
   logic type_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         type_q <= 1'b0;
      end else if (ctrl_we_i) begin
         type_q <= wdata_i[BpCtrlType];
      end
   end

   assign bp_type    = type_q;
   assign pc_match_o = en_q & type_q & ~pc_suppress_i & (pc_i == val_q);
`else
   logic unused_pc;

   assign bp_type    = 1'b0;
   assign pc_match_o = 1'b0;
   assign unused_pc  = ^{pc_i, pc_suppress_i};
`endif

   // Comparison uses the registered values, so a same-cycle host write is not seen.
   assign cycle_match_o = en_q & ~bp_type & (cycle_count_i == val_q);
   assign val_o         = val_q;
   assign ctrl_o        = {bp_type, en_q};

endmodule

// File: rtl/debug_ctrl.sv
// Run-control debug block: halt/resume/step FSM, cycle counter, breakpoints, host registers.
// Define DEBUG_PC_BP_EN to enable PC breakpoints and the skip-once resume logic.
module debug_ctrl
   import debug_pkg::*;
#(
   parameter int unsigned N            = 64,
   parameter int unsigned NUM_BP       = 4,
   parameter bit          RESET_HALTED = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] pc_F,
   input  logic         ebreak_D,
   input  logic [14:0]  ioAddr,
   input  logic         ioWrite,
   input  logic         ioRead,
   input  logic [N-1:0] ioDataOut,
   output logic [N-1:0] ioDataIn,
   output logic         ioReadValid,
   output logic         stall,
   output logic         halted,
   output logic [2:0]   haltCause,
   output logic [N-1:0] cycleCount
);

   dbg_state_e  state_q;
   halt_cause_e cause_q;
   halt_cause_e event_cause;
   logic        halted_q;
   logic [N-1:0] cycle_q, cycle_d;
   logic [N-1:0] rdata, rdata_q;
   logic         rvalid_q;

   logic ctrl_wr, halt_cmd, resume_cmd, step_cmd, clear_cmd, cyc_wr;
   logic halt_event, any_cyc_match, any_pc_match, pc_suppress;

   logic [N-1:0]      bp_val  [NUM_BP];
   logic [1:0]        bp_ctrl [NUM_BP];
   logic [NUM_BP-1:0] cyc_match, pc_match, val_we, ctrl_we;

   assign ctrl_wr    = ioWrite && (ioAddr == AddrCtrl);
   assign halt_cmd   = ctrl_wr & ioDataOut[CtrlHalt];
   assign resume_cmd = ctrl_wr & ioDataOut[CtrlResume];
   assign step_cmd   = ctrl_wr & ioDataOut[CtrlStep];
   assign clear_cmd  = ctrl_wr & ioDataOut[CtrlClear];
   assign cyc_wr     = ioWrite && (ioAddr == AddrCycle);

   for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
      assign val_we[i]  = ioWrite && (ioAddr == AddrBpVal + 15'(i));
      assign ctrl_we[i] = ioWrite && (ioAddr == AddrBpCtrl + 15'(i));

      debug_bp_cmp #(
         .N (N)
      ) u_bp (
         .clk_i         (clk),
         .reset_i       (reset),
         .val_we_i      (val_we[i]),
         .ctrl_we_i     (ctrl_we[i]),
         .wdata_i       (ioDataOut),
         .cycle_count_i (cycle_q),
         .pc_i          (pc_F),
         .pc_suppress_i (pc_suppress),
         .val_o         (bp_val[i]),
         .ctrl_o        (bp_ctrl[i]),
         .cycle_match_o (cyc_match[i]),
         .pc_match_o    (pc_match[i])
      );
   end

   assign any_cyc_match = |cyc_match;
   assign any_pc_match  = |pc_match;
   assign halt_event    = halt_cmd | ebreak_D | any_cyc_match | any_pc_match;
   assign event_cause   = sel_cause(halt_cmd, ebreak_D, any_cyc_match, any_pc_match);
   assign stall         = (state_q == StHalted) | halt_event;

`ifdef DEBUG_PC_BP_EN
   // Masks PC matches for one cycle after leaving HALTED so a resume at a breakpoint moves on.
   logic skip_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skip_q <= 1'b0;
      end else begin
         skip_q <= (state_q == StHalted) && (step_cmd || resume_cmd);
      end
   end

   assign pc_suppress = skip_q;
`else
   assign pc_suppress = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if (RESET_HALTED) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
            cause_q  <= CauseHost;
         end else begin
            state_q  <= StRunning;
            halted_q <= 1'b0;
            cause_q  <= CauseNone;
         end
      end else begin
         if (clear_cmd) begin
            cause_q <= CauseNone;
         end
         unique case (state_q)
            StRunning: begin
               if (halt_event) begin
                  state_q  <= StHalted;
                  halted_q <= 1'b1;
                  cause_q  <= event_cause;
               end
            end
            StHalted: begin
               if (step_cmd) begin
                  state_q  <= StStep;
                  halted_q <= 1'b0;
               end else if (resume_cmd) begin
                  state_q  <= StRunning;
                  halted_q <= 1'b0;
               end
            end
            StStep: begin
               state_q  <= StHalted;
               halted_q <= 1'b1;
               cause_q  <= halt_event ? event_cause : CauseStep;
            end
            default: begin
               state_q  <= StRunning;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      cycle_d = cycle_q;
      if (cyc_wr) begin
         cycle_d = ioDataOut;
      end else if (!stall) begin
         cycle_d = cycle_q + N'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   // Read data is taken from pre-write state, so a coincident write is not reflected.
   always_comb begin
      rdata = '0;
      if (ioAddr == AddrStatus) begin
         rdata = N'({cause_q, halted_q});
      end else if (ioAddr == AddrCycle) begin
         rdata = cycle_q;
      end
      for (int i = 0; i < NUM_BP; i++) begin
         if (ioAddr == AddrBpVal + 15'(i)) begin
            rdata = bp_val[i];
         end
         if (ioAddr == AddrBpCtrl + 15'(i)) begin
            rdata = N'(bp_ctrl[i]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= ioRead;
         if (ioRead) begin
            rdata_q <= rdata;
         end
      end
   end

   assign ioDataIn    = rdata_q;
   assign ioReadValid = rvalid_q;
   assign halted      = halted_q;
   assign haltCause   = cause_q;
   assign cycleCount  = cycle_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed self-checking bench for debug_ctrl (default parameters).
// PC-breakpoint checks run only when DEBUG_PC_BP_EN is defined.
module tb_debug_ctrl;

   localparam int unsigned N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] pc_F;
   logic         ebreak_D;
   logic [14:0]  ioAddr;
   logic         ioWrite;
   logic         ioRead;
   logic [N-1:0] ioDataOut;
   logic [N-1:0] ioDataIn;
   logic         ioReadValid;
   logic         stall;
   logic         halted;
   logic [2:0]   haltCause;
   logic [N-1:0] cycleCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debug_ctrl #(
      .N            (N),
      .NUM_BP       (4),
      .RESET_HALTED (1'b0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_F        (pc_F),
      .ebreak_D    (ebreak_D),
      .ioAddr      (ioAddr),
      .ioWrite     (ioWrite),
      .ioRead      (ioRead),
      .ioDataOut   (ioDataOut),
      .ioDataIn    (ioDataIn),
      .ioReadValid (ioReadValid),
      .stall       (stall),
      .halted      (halted),
      .haltCause   (haltCause),
      .cycleCount  (cycleCount)
   );

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; the fetch PC advances by 4 on every unstalled cycle.
   task automatic tick();
      logic st;
      #1;
      st = stall;
      @(posedge clk);
      #1;
      if (!st) pc_F = pc_F + 4;
   endtask

   task automatic wr(input logic [14:0] a, input logic [N-1:0] d);
      ioAddr    = a;
      ioDataOut = d;
      ioWrite   = 1'b1;
      tick();
      ioWrite   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [14:0] a, input logic [N-1:0] exp);
      ioAddr = a;
      ioRead = 1'b1;
      tick();
      ioRead = 1'b0;
      check({tag, "_valid"}, N'(ioReadValid), N'(1));
      check(tag, ioDataIn, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset     = 1'b1;
      pc_F      = '0;
      ebreak_D  = 1'b0;
      ioAddr    = '0;
      ioWrite   = 1'b0;
      ioRead    = 1'b0;
      ioDataOut = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_halted", N'(halted), N'(0));
      check("rst_cause", N'(haltCause), N'(0));
      check("rst_count", cycleCount, N'(0));
      check("rst_rvalid", N'(ioReadValid), N'(0));
      check("rst_stall", N'(stall), N'(0));
      reset = 1'b0;

      repeat (3) tick();
      check("run_count3", cycleCount, N'(3));

      // Cycle breakpoint at 100.
      wr(15'h010, N'(100));
      wr(15'h020, N'(1));
      rd("bpval0", 15'h010, N'(100));
      rd("bpctrl0", 15'h020, N'(1));
      n = 0;
      while (cycleCount != N'(100) && n < 200) begin
         tick();
         n++;
      end
      check("reach_100", cycleCount, N'(100));
      #1;
      check("bp_stall", N'(stall), N'(1));
      check("bp_not_yet_halted", N'(halted), N'(0));
      tick();
      check("bp_halted", N'(halted), N'(1));
      check("bp_count_held", cycleCount, N'(100));
      check("bp_cause", N'(haltCause), N'(3));
      rd("status_bp", 15'h001, N'(7));

      // Host halt and ebreak together: host wins.
      wr(15'h020, N'(0));
      wr(15'h000, N'(2));
      check("resumed", N'(halted), N'(0));
      tick();
      check("count_101", cycleCount, N'(101));
      ioAddr    = 15'h000;
      ioDataOut = N'(1);
      ioWrite   = 1'b1;
      ebreak_D  = 1'b1;
      #1;
      check("host_ebreak_stall", N'(stall), N'(1));
      tick();
      ioWrite  = 1'b0;
      ebreak_D = 1'b0;
      check("host_ebreak_halted", N'(halted), N'(1));
      check("host_ebreak_cause", N'(haltCause), N'(1));
      wr(15'h000, N'(8));
      rd("status_cleared", 15'h001, N'(1));

      // Ebreak alone.
      wr(15'h000, N'(2));
      ebreak_D = 1'b1;
      tick();
      ebreak_D = 1'b0;
      check("ebreak_cause", N'(haltCause), N'(2));
      check("ebreak_count", cycleCount, N'(101));

      // Three single steps, then resume+step together (step wins).
      for (int s = 0; s < 3; s++) begin
         wr(15'h000, N'(4));
         check("step_running", N'(halted), N'(0));
         tick();
         check("step_halted", N'(halted), N'(1));
         check("step_cause", N'(haltCause), N'(5));
      end
      check("step_count", cycleCount, N'(104));
      wr(15'h000, N'(6));
      tick();
      check("step_wins_count", cycleCount, N'(105));
      check("step_wins_halted", N'(halted), N'(1));
      rd("status_step", 15'h001, N'(11));

      // Simultaneous read and write of cycleCount.
      ioAddr    = 15'h002;
      ioDataOut = N'(500);
      ioWrite   = 1'b1;
      ioRead    = 1'b1;
      tick();
      ioWrite = 1'b0;
      ioRead  = 1'b0;
      check("rw_old_data", ioDataIn, N'(105));
      check("rw_new_count", cycleCount, N'(500));

      // Unmapped and write-only addresses.
      rd("unmapped_100", 15'h100, N'(0));
      rd("unmapped_bp4", 15'h014, N'(0));
      rd("ctrl_wo", 15'h000, N'(0));

      wr(15'h021, N'(3));
`ifdef DEBUG_PC_BP_EN
      rd("bpctrl_type", 15'h021, N'(3));
`else
      rd("bpctrl_type", 15'h021, N'(1));
`endif
      wr(15'h021, N'(0));

      // Counter wrap.
      wr(15'h002, {N{1'b1}});
      wr(15'h000, N'(2));
      check("wrap_max", cycleCount, {N{1'b1}});
      tick();
      check("wrap_zero", cycleCount, N'(0));
      check("rvalid_idle", N'(ioReadValid), N'(0));

`ifdef DEBUG_PC_BP_EN
      // PC breakpoint with skip-once on resume.
      pc_F = '0;
      wr(15'h011, N'('h40));
      wr(15'h021, N'(3));
      n = 0;
      while (!halted && n < 64) begin
         tick();
         n++;
      end
      check("pcbp_halted", N'(halted), N'(1));
      check("pcbp_pc", pc_F, N'('h40));
      check("pcbp_cause", N'(haltCause), N'(4));
      wr(15'h000, N'(2));
      tick();
      tick();
      check("pcbp_no_rehalt", N'(halted), N'(0));
      check("pcbp_pc_past", pc_F, N'('h48));
      wr(15'h021, N'(0));
`endif

      // Reset during STEP with a read in flight.
      wr(15'h000, N'(1));
      rd("status_host", 15'h001, N'(3));
      wr(15'h000, N'(4));
      check("pre_rst_step", N'(halted), N'(0));
      ioAddr = 15'h002;
      ioRead = 1'b1;
      reset  = 1'b1;
      #1;
      check("mid_rst_halted", N'(halted), N'(0));
      check("mid_rst_cause", N'(haltCause), N'(0));
      check("mid_rst_count", cycleCount, N'(0));
      check("mid_rst_rvalid", N'(ioReadValid), N'(0));
      check("mid_rst_rdata", ioDataIn, N'(0));
      repeat (2) @(posedge clk);
      #1;
      ioRead = 1'b0;
      reset  = 1'b0;
      tick();
      check("post_rst_rvalid", N'(ioReadValid), N'(0));
      check("post_rst_running", N'(halted), N'(0));
      check("post_rst_count", cycleCount, N'(1));
      rd("post_rst_bpval", 15'h010, N'(0));
      rd("post_rst_bpctrl", 15'h020, N'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 SHALL have parameter N, default 64, meaning datapath/counter width.
REQ-002 SHALL have parameter NUM_BP, default 4, range 1..16, meaning breakpoint channel count.
REQ-003 SHALL have parameter RESET_HALTED, default 0, meaning state entered on reset (1 = HALTED).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports pc_F in N (fetch PC), ebreak_D in 1 (ebreak decoded).
REQ-007 SHALL have ports ioAddr in 15, ioWrite in 1, ioRead in 1, ioDataOut in N (host to block).
REQ-008 SHALL have ports ioDataIn out N, ioReadValid out 1 (block to host).
REQ-009 SHALL have ports stall out 1, halted out 1, haltCause out 3, cycleCount out N.

Function
REQ-010 SHALL implement states RUNNING, HALTED, STEP.
REQ-011 RUNNING->HALTED SHALL occur on haltEvent = host halt | ebreak_D | any enabled breakpoint match.
REQ-012 HALTED->RUNNING on resume command; HALTED->STEP on step command; step wins if both written.
REQ-013 STEP SHALL last exactly one unstalled cycle, then HALTED with cause STEP, unless a haltEvent in that cycle sets its own cause.
REQ-014 stall SHALL be combinational: (state==HALTED) | (state!=HALTED & haltEvent).
REQ-015 halted SHALL equal (state==HALTED), registered.
REQ-016 haltCause encoding: 0 none, 1 host, 2 ebreak, 3 cycle bp, 4 PC bp, 5 step; priority host > ebreak > cycle bp > PC bp.
REQ-017 haltCause SHALL hold until next halt or clear-cause command.
REQ-018 cycleCount SHALL increment by 1 each cycle stall==0 and wrap 2^N-1 -> 0.
REQ-019 Channel i match: enable & (type==cycle ? cycleCount==bpVal[i] : pc_F==bpVal[i]); channels evaluated in parallel.
REQ-020 PC matches SHALL be suppressed in the first cycle after leaving HALTED (skip-once) so resume at a breakpoint progresses.
REQ-021 Register map (ioAddr): 0x000 CTRL write-only (bit0 halt, bit1 resume, bit2 step, bit3 clear cause); 0x001 STATUS {cause[3:1], halted[0]}; 0x002 cycleCount (R/W); 0x010+i bpVal[i]; 0x020+i bpCtrl[i] {type[1], enable[0]}.
REQ-022 Reads SHALL return ioDataIn with ioReadValid one cycle after ioRead; unmapped addresses read 0, writes ignored.
REQ-023 Host write to cycleCount SHALL override increment in the same cycle.
REQ-024 Host write to bpVal/bpCtrl coincident with a match SHALL use pre-write values for that cycle's match.
REQ-025 ioRead and ioWrite together: write takes effect, read returns pre-write value.

Reset
REQ-026 On reset: state = RESET_HALTED ? HALTED : RUNNING, haltCause 0 (1 if RESET_HALTED), cycleCount 0, all bpVal/bpCtrl 0, ioDataIn 0, ioReadValid 0, skip-once flag 0.
REQ-027 Reset during STEP or pending read SHALL abort it; no ioReadValid after reset release.

Configuration
REQ-028 Macro DEBUG_PC_BP_EN defined: PC-type breakpoints and skip-once logic present.
REQ-029 Macro undefined: bpCtrl type bit forced 0 (reads 0, writes ignored), cause 4 never produced.

Structure
REQ-030 Package debug_pkg SHALL hold state enum, haltCause encoding, register address constants, CTRL bit positions.
REQ-031 Sub-module debug_bp_cmp SHALL implement one breakpoint channel (registers + comparator), instantiated NUM_BP times.

Verification
REQ-032 Write bpVal[0]=100, bpCtrl[0]=1 -> stall asserts in cycle cycleCount==100, halted next cycle, STATUS reads 0x7.
REQ-033 PC bp at 0x40 (type 1), run to halt, write resume -> pc_F advances past 0x40 without re-halt.
REQ-034 Halted, write step three times -> cycleCount advances exactly 3, cause 5 each time.
REQ-035 ebreak_D and host halt in same cycle -> cause 1; then clear-cause -> STATUS reads 0x1.
REQ-036 Write cycleCount = 2^N-1, resume -> next value 0; assert reset mid-STEP -> state RUNNING, all registers 0.
